dmem_sram_bridge: RTL
=====================

// Module: dmem_sram_bridge
// PURPOSE
//  MEM-stage bridge between the pipelined datapath and an SRAM-like data bus (req/addr_ok/data_ok).
//  Issues exactly one bus transaction per load/store sitting in MEM and stalls the pipeline until it completes.
//  Holds load data stable while another unit keeps MEM frozen. Load data feeds the MEM/WB register (readdataM).
// PARAMETERS
//  AW  32  address width
//  DW  32  data width (fixed 32; wstrb is DW/8)
// PORTS
//  clk           in   1   clock; all state changes on rising edge
//  rst           in   1   synchronous reset, active-high
//  mem_req_M     in   1   MEM instruction is a load or store (already gated by flush)
//  memwriteM     in   1   1 = store, 0 = load
//  mem_size_M    in   2   0 = byte, 1 = half, 2 = word
//  sig_write     in   4   store byte strobes from the write_data block
//  aluoutM       in   AW  effective address
//  writedataM    in   DW  lane-aligned store data
//  pipe_stall    in   1   another source is holding MEM this cycle (hazard unit / div stall)
//  readdataM     out  DW  load data to MEM/WB register
//  stall_memM    out  1   bridge is holding the pipeline
//  addr_err_M    out  1   misaligned access flag (see CONFIGURATION)
//  data_req      out  1   bus request
//  data_wr       out  1   bus write
//  data_size     out  2   bus size (= mem_size_M)
//  data_wstrb    out  4   byte strobes (sig_write on stores, 0 on loads)
//  data_addr     out  AW  bus address (= aluoutM)
//  data_wdata    out  DW  bus write data (= writedataM)
//  data_addr_ok  in   1   slave accepted request
//  data_rdata    in   DW  read data, valid with data_ok
//  data_data_ok  in   1   transaction complete (never before the cycle after addr_ok)
// BEHAVIOUR
//  FSM states: IDLE, REQ, WAIT, DONE. Reset: state = IDLE, rdata_q = 0.
//  Reset values: readdataM = 0, stall_memM = 0, data_req = 0, addr_err_M = 0.
//  data_req = (IDLE & mem_req_M & ~err) | REQ. Address, data, size and strobes are driven combinationally from the MEM inputs.
//  Transitions:
//   - IDLE --(req & addr_ok)--> WAIT
//   - IDLE --(req & ~addr_ok)--> REQ
//   - REQ --(addr_ok)--> WAIT
//   - WAIT --(data_ok & pipe_stall)--> DONE
//   - WAIT --(data_ok & ~pipe_stall)--> IDLE
//   - DONE --(~pipe_stall)--> IDLE
//  stall_memM = (IDLE & mem_req_M & ~err) | REQ | (WAIT & ~data_ok). It is 0 in DONE.
//  readdataM = data_rdata when (WAIT & data_ok), else rdata_q. rdata_q captures data_rdata on that edge.
//  Store latency: the same handshake applies. Store completion also waits for data_ok. readdataM is don't-care for stores.
//  Minimum latency is 2 cycles: request and addr_ok in cycle 0, data_ok in cycle 1, stall_memM low in cycle 1.
//  data_addr_ok / data_data_ok arriving in an unexpected state (data_ok in IDLE/REQ, addr_ok in WAIT/DONE) are ignored.
//  No re-issue: DONE blocks a new request while the same instruction stays in MEM under pipe_stall.
//  Back-to-back: on the cycle WAIT->IDLE with ~pipe_stall the pipeline advances. The next load/store issues in the following cycle.
//  Request outputs are held stable from issue until addr_ok (MEM is frozen by stall_memM).
//  rst mid-transaction returns to IDLE. The bus slave shares rst, so no response is outstanding afterwards.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//   - err = mem_req_M & ((size==1 & addr[0]) | (size==2 & addr[1:0]!=0)).
//   - addr_err_M = err in IDLE. No bus request is issued and stall_memM = 0 (the exception unit consumes the flag).
//  DMEM_ALIGN_CHECK_EN not defined: err is tied 0, addr_err_M is tied 0, all accesses are issued unchanged.
// TESTING
//  1. Load word at 0x100: addr_ok in cycle 0, data_ok+rdata 0xDEADBEEF in cycle 1 -> 1 req, stall 1 cycle, readdataM = 0xDEADBEEF.
//  2. Store byte at 0x103, sig_write 4'b1000: addr_ok delayed 3 cycles, data_ok 2 later -> data_req held 4 cycles, wstrb 1000, stall_memM low only at data_ok.
//  3. Load completes with pipe_stall = 1 for 3 cycles -> state DONE, readdataM holds 0x12345678, exactly 1 bus request total.
//  4. Two back-to-back loads (0x200, 0x204) -> two distinct requests, no overlap, each readdataM correct at its stall release.
//  5. rst asserted while in WAIT -> next cycle IDLE, data_req = 0, stall_memM = 0, readdataM = 0.
//  6. DMEM_ALIGN_CHECK_EN defined, load word at 0x102 -> addr_err_M = 1, data_req = 0, stall_memM = 0. Undefined -> request issued normally.

Source files
------------

// File: rtl/dmem_sram_bridge.sv
// MEM-stage bridge from the pipeline to an SRAM-like req/addr_ok/data_ok bus: one transaction per load/store.
// Optional misalignment trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_sram_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_req_M,
    input  logic            memwriteM,
    input  logic [1:0]      mem_size_M,
    input  logic [DW/8-1:0] sig_write,
    input  logic [AW-1:0]   aluoutM,
    input  logic [DW-1:0]   writedataM,
    input  logic            pipe_stall,
    output logic [DW-1:0]   readdataM,
    output logic            stall_memM,
    output logic            addr_err_M,
    output logic            data_req,
    output logic            data_wr,
    output logic [1:0]      data_size,
    output logic [DW/8-1:0] data_wstrb,
    output logic [AW-1:0]   data_addr,
    output logic [DW-1:0]   data_wdata,
    input  logic            data_addr_ok,
    input  logic [DW-1:0]   data_rdata,
    input  logic            data_data_ok
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    logic [DW-1:0] rdata_q;
    logic          err;
    logic          issue;
    logic          in_idle, in_req, in_wait;

`ifdef DMEM_ALIGN_CHECK_EN
    assign err = mem_req_M & (((mem_size_M == 2'd1) & aluoutM[0]) |
                              ((mem_size_M == 2'd2) & (aluoutM[1:0] != 2'b00)));
`else
    assign err = 1'b0;
`endif

    assign in_idle = (state == IDLE);
    assign in_req  = (state == REQ);
    assign in_wait = (state == WAIT);

    // DONE deliberately never issues: the finished instruction may still sit in MEM under pipe_stall.
    assign issue      = in_idle & mem_req_M & ~err;
    assign data_req   = issue | in_req;
    assign stall_memM = issue | in_req | (in_wait & ~data_data_ok);
    assign addr_err_M = in_idle & err;

    assign data_wr    = memwriteM;
    assign data_size  = mem_size_M;
    assign data_addr  = aluoutM;
    assign data_wdata = writedataM;
    assign data_wstrb = memwriteM ? sig_write : '0;

    // Bypass on the completion cycle so MEM/WB captures data without an extra stall cycle.
    assign readdataM = (in_wait & data_data_ok) ? data_rdata : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (issue) state <= data_addr_ok ? WAIT : REQ;
                REQ:  if (data_addr_ok) state <= WAIT;
                WAIT: if (data_data_ok) begin
                    rdata_q <= data_rdata;
                    state   <= pipe_stall ? DONE : IDLE;
                end
                DONE: if (!pipe_stall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
